// File: rtl/bs_host_if_pkg.sv
// bs_pkg: shared definitions for the Black-Scholes host interface.
//   - word addresses of the register map
//   - CTRL / STATUS bit positions
//   - FSM state encoding
//   - default position of the done flag inside proc_status
//   - sat16(): clamps a wide count to 16 bits for the CYCLES register
package bs_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CONSTK = 3'd2;
    localparam logic [2:0] ADDR_CONST1 = 3'd3;
    localparam logic [2:0] ADDR_CONST2 = 3'd4;
    localparam logic [2:0] ADDR_CONST3 = 3'd5;
    localparam logic [2:0] ADDR_RESULT = 3'd6;
    localparam logic [2:0] ADDR_CYCLES = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_CLR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_PROC_LSB = 4;

    localparam int DONE_BIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/bs_host_if_if.sv
// bs_bus_if: word-addressed register bus between the system fabric and
// bs_host_if.
//   address[2:0]    word address
//   write/writedata write strobe and data
//   read/readdata   read strobe and registered read data
//   irq             level interrupt back to the host
// master modport: bus initiator; slave modport: bs_host_if.
interface bs_bus_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, write, writedata, read,
                    input  readdata, irq);
    modport slave  (input  address, write, writedata, read,
                    output readdata, irq);
endinterface

// File: rtl/bs_host_if.sv
// bs_host_if: host-side initiator for the Black-Scholes processor.
// Software loads the constants, writes start; the block pulses req for one
// cycle, waits for a rising edge on the processor's done flag (or a timeout),
// captures the result and optionally raises a level interrupt.
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   bus (slave)          register bus: address/write/writedata/read/readdata/irq
//   constK, const1..3    operands to the processor, frozen while busy
//   req                  one-cycle start pulse to the processor
//   proc_status[4:0]     processor status, bit DONE_BIT = done flag
//   proc_dout[31:0]      processor result
module bs_host_if
    import bs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DONE_BIT       = DONE_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        nreset,
    bs_bus_if.slave     bus,
    output logic [31:0] constK,
    output logic [31:0] const1,
    output logic [31:0] const2,
    output logic [31:0] const3,
    output logic        req,
    input  logic [4:0]  proc_status,
    input  logic [31:0] proc_dout
);

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      r_state, w_next;
    logic        r_done_prev, r_done, r_timeout, r_irq, r_irq_en;
    logic [31:0] r_constk, r_const1, r_const2, r_const3;
    logic [31:0] r_result, r_dout_cap, r_cnt, r_readdata;

    logic        w_busy, w_wr_ctrl, w_start, w_irq_clr, w_done_edge;
    logic        w_launch, w_edge_seen, w_capture, w_to;
    logic [31:0] w_cnt_inc, w_rdata;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_wr_ctrl   = bus.write && (bus.address == ADDR_CTRL);
    assign w_start     = w_wr_ctrl && bus.writedata[CTRL_START];
    assign w_irq_clr   = w_wr_ctrl && bus.writedata[CTRL_IRQ_CLR];
    // Only a low-to-high transition counts; a done level already high when
    // WAIT is entered was seen by r_done_prev during LAUNCH and is ignored.
    assign w_done_edge = proc_status[DONE_BIT] && !r_done_prev;
    assign w_cnt_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // FSM next state and one-cycle event strobes
    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_edge_seen = 1'b0;
        w_capture   = 1'b0;
        w_to        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next   = ST_LAUNCH;
                    w_launch = 1'b1;
                end
            end
            ST_LAUNCH: w_next = ST_WAIT;
            ST_WAIT: begin
                // An edge in the same cycle the limit is reached still wins.
                if (w_done_edge) begin
                    w_next      = ST_CAPTURE;
                    w_edge_seen = 1'b1;
                end else if (w_cnt_inc >= TO_LIMIT) begin
                    w_next = ST_IDLE;
                    w_to   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_next    = ST_IDLE;
                w_capture = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = 32'h0;
        case (bus.address)
            ADDR_CTRL:   w_rdata[CTRL_IRQ_EN] = r_irq_en;
            ADDR_STATUS: begin
                w_rdata[STAT_BUSY]                    = w_busy;
                w_rdata[STAT_DONE]                    = r_done;
                w_rdata[STAT_TIMEOUT]                 = r_timeout;
                w_rdata[STAT_PROC_LSB +: 5]           = proc_status;
            end
            ADDR_CONSTK: w_rdata = r_constk;
            ADDR_CONST1: w_rdata = r_const1;
            ADDR_CONST2: w_rdata = r_const2;
            ADDR_CONST3: w_rdata = r_const3;
            ADDR_RESULT: w_rdata = r_result;
            ADDR_CYCLES: w_rdata = {16'h0, sat16(r_cnt)};
            default:     w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_done_prev <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_irq       <= 1'b0;
            r_irq_en    <= 1'b0;
            r_constk    <= 32'h0;
            r_const1    <= 32'h0;
            r_const2    <= 32'h0;
            r_const3    <= 32'h0;
            r_result    <= 32'h0;
            r_dout_cap  <= 32'h0;
            r_cnt       <= 32'h0;
            r_readdata  <= 32'h0;
        end else begin
            r_done_prev <= proc_status[DONE_BIT];

            if (w_launch) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
                r_cnt     <= 32'h0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            // proc_dout is taken in the edge cycle, published one cycle later.
            if (w_edge_seen) r_dout_cap <= proc_dout;
            if (w_capture) begin
                r_result <= r_dout_cap;
                r_done   <= 1'b1;
            end
            if (w_to) r_timeout <= 1'b1;

            if (w_wr_ctrl) r_irq_en <= bus.writedata[CTRL_IRQ_EN];

            if ((w_capture || w_to) && r_irq_en) r_irq <= 1'b1;
            else if (w_irq_clr || w_launch)      r_irq <= 1'b0;

            if (bus.write && !w_busy) begin
                case (bus.address)
                    ADDR_CONSTK: r_constk <= bus.writedata;
                    ADDR_CONST1: r_const1 <= bus.writedata;
                    ADDR_CONST2: r_const2 <= bus.writedata;
                    ADDR_CONST3: r_const3 <= bus.writedata;
                    default: ;
                endcase
            end

            if (bus.read) r_readdata <= w_rdata;
        end
    end

    assign req          = (r_state == ST_LAUNCH);
    assign constK       = r_constk;
    assign const1       = r_const1;
    assign const2       = r_const2;
    assign const3       = r_const3;
    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;

endmodule

// File: tb/tb_bs_host_if.sv
module tb_bs_host_if;
    import bs_pkg::*;

    localparam int DLY = 12;

    logic        clk = 1'b0;
    logic        nreset;
    logic [31:0] constK, const1, const2, const3;
    logic        req;
    logic [4:0]  proc_status = 5'h0;
    logic [31:0] proc_dout = 32'h0;

    always #5 clk = ~clk;

    bs_bus_if bus();

    bs_host_if #(.TIMEOUT_CYCLES(16), .DONE_BIT(4)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus),
        .constK      (constK),
        .const1      (const1),
        .const2      (const2),
        .const3      (const3),
        .req         (req),
        .proc_status (proc_status),
        .proc_dout   (proc_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Processor model: mode 0 raises done DLY cycles after req for two cycles,
    // mode 1 never raises done, mode 2 holds done high permanently.
    int          mode = 0;
    int          pc = -1;
    logic [31:0] model_dout = 32'h0;
    int          req_total = 0;

    always @(negedge clk or negedge nreset) begin
        if (!nreset) pc = -1;
        else if (req) pc = 0;
        else if (pc >= 0 && pc < 100) pc++;
        proc_status = (mode == 2 || (mode == 0 && (pc == DLY || pc == DLY + 1))) ? 5'h10 : 5'h00;
        proc_dout   = (mode == 0 && pc >= DLY) ? model_dout : 32'h0;
    end

    always @(posedge clk) if (req === 1'b1) req_total++;

    // Scoreboard of expected read data
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(posedge clk); #1;
        bus.write     = 1'b0;
    endtask

    task automatic bus_read_raw(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        @(posedge clk); #1;
        bus.read    = 1'b0;
        d = bus.readdata;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_read_raw(a, d);
        chk(tag_q.pop_front(), d, exp_q.pop_front());
    endtask

    task automatic wait_idle(input int maxc);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            bus_read_raw(ADDR_STATUS, d);
            if (!d[STAT_BUSY]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle", {31'h0, ok}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.address   = 3'h0;
        bus.write     = 1'b0;
        bus.writedata = 32'h0;
        bus.read      = 1'b0;
        nreset        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_constK", constK, 32'h0);
        chk("rst_readdata", bus.readdata, 32'h0);
        nreset = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, $sformatf("rst_rd%0d", a));

        // Basic run
        bus_write(ADDR_CONSTK, 32'h42C8_0000);
        chk("constK_port", constK, 32'h42C8_0000);
        rd_chk(ADDR_CONSTK, 32'h42C8_0000, "constK_rd");
        model_dout = 32'h3F9E_0419;
        base = req_total;
        bus_write(ADDR_CTRL, 32'h1);
        chk("req_launch", {31'h0, req}, 32'h1);
        @(posedge clk); #1;
        chk("req_one_cycle", {31'h0, req}, 32'h0);
        rd_chk(ADDR_STATUS, 32'h1, "status_run");
        wait_idle(60);
        rd_chk(ADDR_STATUS, 32'h2, "status_done");
        rd_chk(ADDR_RESULT, 32'h3F9E_0419, "result");
        rd_chk(ADDR_CYCLES, 32'd12, "cycles");
        chk("req_count", 32'(req_total - base), 32'h1);

        // Interrupt
        bus_write(ADDR_CTRL, 32'h4);
        rd_chk(ADDR_CTRL, 32'h4, "ctrl_rd");
        bus_write(ADDR_CTRL, 32'h5);
        chk("irq_run", {31'h0, bus.irq}, 32'h0);
        wait_idle(60);
        chk("irq_set", {31'h0, bus.irq}, 32'h1);
        bus_write(ADDR_CTRL, 32'h6);
        chk("irq_clear", {31'h0, bus.irq}, 32'h0);
        bus_write(ADDR_CTRL, 32'h5);
        wait_idle(60);
        chk("irq_set2", {31'h0, bus.irq}, 32'h1);
        bus_write(ADDR_CTRL, 32'h7);
        chk("irq_start_clr", {31'h0, bus.irq}, 32'h0);
        chk("req_start_clr", {31'h0, req}, 32'h1);
        wait_idle(60);
        chk("irq_set3", {31'h0, bus.irq}, 32'h1);
        bus_write(ADDR_CTRL, 32'h2);
        chk("irq_clear2", {31'h0, bus.irq}, 32'h0);

        // Writes while busy are ignored
        bus_write(ADDR_CONST1, 32'h1111_1111);
        model_dout = 32'hCAFE_0001;
        base = req_total;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CONST1, 32'hDEAD_BEEF);
        bus_write(ADDR_CTRL, 32'h1);
        wait_idle(60);
        chk("const1_port", const1, 32'h1111_1111);
        rd_chk(ADDR_CONST1, 32'h1111_1111, "const1_rd");
        chk("req_count_busy", 32'(req_total - base), 32'h1);
        rd_chk(ADDR_RESULT, 32'hCAFE_0001, "result2");

        // Timeout: done never asserted
        mode = 1;
        bus_write(ADDR_CTRL, 32'h5);
        wait_idle(60);
        rd_chk(ADDR_STATUS, 32'h4, "to_status");
        rd_chk(ADDR_RESULT, 32'hCAFE_0001, "to_result");
        rd_chk(ADDR_CYCLES, 32'd16, "to_cycles");
        chk("to_irq", {31'h0, bus.irq}, 32'h1);

        // Timeout: done stuck high from before start
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        bus_write(ADDR_CTRL, 32'h5);
        wait_idle(60);
        rd_chk(ADDR_STATUS, 32'h104, "stuck_status");
        rd_chk(ADDR_RESULT, 32'hCAFE_0001, "stuck_result");
        chk("stuck_irq", {31'h0, bus.irq}, 32'h1);
        mode = 0;
        bus_write(ADDR_CTRL, 32'h2);
        rd_chk(ADDR_CYCLES, 32'd16, "stuck_cycles");

        // Asynchronous reset mid-run
        bus_write(ADDR_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("arst_constK", constK, 32'h0);
        chk("arst_readdata", bus.readdata, 32'h0);
        chk("arst_req", {31'h0, req}, 32'h0);
        chk("arst_irq", {31'h0, bus.irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        rd_chk(ADDR_STATUS, 32'h0, "arst_status");
        rd_chk(ADDR_RESULT, 32'h0, "arst_result");
        bus_write(ADDR_CONSTK, 32'h42C8_0000);
        model_dout = 32'h1234_5678;
        bus_write(ADDR_CTRL, 32'h1);
        wait_idle(60);
        rd_chk(ADDR_RESULT, 32'h1234_5678, "post_rst_result");
        rd_chk(ADDR_CYCLES, 32'd12, "post_rst_cycles");
        rd_chk(ADDR_STATUS, 32'h2, "post_rst_status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
